rsa_precomp_streamer: RTL and testbench

RSA_PRECOMP_STREAMER -- requirements
Module: rsa_precomp_streamer

---
 rtl/rsa_precomp_streamer.sv | 247 ++++++++++++++++++++++++
 tb/tb_rsa_precomp_streamer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_precomp_streamer.sv
// rsa_precomp_streamer
// Latches a modulus n, launches the n0' and r/t precomputation engines with a
// single pulse, captures their results as they complete (in any order), then
// streams r and t out one DATA_WIDTH word per accepted transfer.
//
// Optional feature: define RSA_PRECOMP_TIMEOUT_EN to bound the engine wait to
// TIMEOUT cycles. On expiry the run is abandoned with a one-cycle error pulse.
// Without the macro the wait is unbounded and error is tied low.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start, n             request a precomputation for modulus n (IDLE only)
//   n_lat                latched modulus feeding both engines
//   eng_start            one-cycle engine launch pulse
//   n0p_done, n0p_in     n0' engine completion pulse and result
//   rt_done, r_in, t_in  r/t engine completion pulse and results
//   out_valid, out_ready stream handshake
//   r, t, word_idx, last current stream word, its index, final-word flag
//   n0p                  captured n0'
//   busy, done, error    status
module rsa_precomp_streamer #(
    parameter int unsigned DATA_LENGTH = 1024,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned MSW_FIRST   = 1,
    parameter int unsigned TIMEOUT     = 4096,
    localparam int unsigned WORDS      = DATA_LENGTH / DATA_WIDTH,
    localparam int unsigned IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_LENGTH-1:0] n,
    output logic [DATA_LENGTH-1:0] n_lat,
    output logic                   eng_start,
    input  logic                   n0p_done,
    input  logic                   rt_done,
    input  logic [DATA_WIDTH-1:0]  n0p_in,
    input  logic [DATA_LENGTH-1:0] r_in,
    input  logic [DATA_LENGTH-1:0] t_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  r,
    output logic [DATA_WIDTH-1:0]  t,
    output logic [DATA_WIDTH-1:0]  n0p,
    output logic [IDX_W-1:0]       word_idx,
    output logic                   last,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int unsigned BIT_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_STREAM = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_LENGTH-1:0] n_lat_q, n_lat_d;
    logic [DATA_LENGTH-1:0] r_buf_q, r_buf_d;
    logic [DATA_LENGTH-1:0] t_buf_q, t_buf_d;
    logic [DATA_WIDTH-1:0]  n0p_q, n0p_d;
    logic                   n0p_flag_q, n0p_flag_d;
    logic                   rt_flag_q, rt_flag_d;
    logic [IDX_W-1:0]       word_idx_q, word_idx_d;
    logic [DATA_WIDTH-1:0]  r_q, r_d;
    logic [DATA_WIDTH-1:0]  t_q, t_d;
    logic                   last_q, last_d;
    logic                   eng_start_q, eng_start_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

`ifdef RSA_PRECOMP_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Selects stream word k of v in the configured word order.
    function automatic logic [DATA_WIDTH-1:0] word_of(input logic [DATA_LENGTH-1:0] v,
                                                      input logic [IDX_W-1:0]       k);
        int unsigned      slot;
        logic [BIT_W-1:0] base;
        if (MSW_FIRST != 0) begin
            slot = WORDS - 1 - 32'(k);
        end else begin
            slot = 32'(k);
        end
        base = BIT_W'(slot * DATA_WIDTH);
        return v[base +: DATA_WIDTH];
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        n_lat_d     = n_lat_q;
        r_buf_d     = r_buf_q;
        t_buf_d     = t_buf_q;
        n0p_d       = n0p_q;
        n0p_flag_d  = n0p_flag_q;
        rt_flag_d   = rt_flag_q;
        word_idx_d  = word_idx_q;
        r_d         = '0;
        t_d         = '0;
        last_d      = 1'b0;
        eng_start_d = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;
`ifdef RSA_PRECOMP_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_lat_d    = n;
                    n0p_flag_d = 1'b0;
                    rt_flag_d  = 1'b0;
`ifdef RSA_PRECOMP_TIMEOUT_EN
                    tmo_cnt_d  = '0;
`endif
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // First completion pulse wins; repeats are ignored via the sticky flags.
                if (n0p_done && !n0p_flag_q) begin
                    n0p_d      = n0p_in;
                    n0p_flag_d = 1'b1;
                end
                if (rt_done && !rt_flag_q) begin
                    r_buf_d   = r_in;
                    t_buf_d   = t_in;
                    rt_flag_d = 1'b1;
                end
                if (n0p_flag_d && rt_flag_d) begin
                    state_d    = S_STREAM;
                    word_idx_d = '0;
                end
`ifdef RSA_PRECOMP_TIMEOUT_EN
                else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
`endif
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = S_FIN;
                    end else begin
                        word_idx_d = word_idx_q + IDX_W'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered: derive them from the state being entered.
        eng_start_d = (state_d == S_LAUNCH);
        out_valid_d = (state_d == S_STREAM);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FIN);
        if (state_d == S_STREAM) begin
            r_d    = word_of(r_buf_d, word_idx_d);
            t_d    = word_of(t_buf_d, word_idx_d);
            last_d = (word_idx_d == IDX_W'(WORDS - 1));
        end else begin
            word_idx_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_lat_q     <= '0;
            r_buf_q     <= '0;
            t_buf_q     <= '0;
            n0p_q       <= '0;
            n0p_flag_q  <= 1'b0;
            rt_flag_q   <= 1'b0;
            word_idx_q  <= '0;
            r_q         <= '0;
            t_q         <= '0;
            last_q      <= 1'b0;
            eng_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef RSA_PRECOMP_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            n_lat_q     <= n_lat_d;
            r_buf_q     <= r_buf_d;
            t_buf_q     <= t_buf_d;
            n0p_q       <= n0p_d;
            n0p_flag_q  <= n0p_flag_d;
            rt_flag_q   <= rt_flag_d;
            word_idx_q  <= word_idx_d;
            r_q         <= r_d;
            t_q         <= t_d;
            last_q      <= last_d;
            eng_start_q <= eng_start_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef RSA_PRECOMP_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign n_lat     = n_lat_q;
    assign eng_start = eng_start_q;
    assign out_valid = out_valid_q;
    assign r         = r_q;
    assign t         = t_q;
    assign n0p       = n0p_q;
    assign word_idx  = word_idx_q;
    assign last      = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_rsa_precomp_streamer.sv
// Testbench for rsa_precomp_streamer: two instances (MSW-first and LSW-first)
// share all inputs; a word-list model of each run predicts status and stream.
module tb_rsa_precomp_streamer;

    localparam int DL    = 256;
    localparam int DW    = 64;
    localparam int WORDS = DL / DW;

    logic          clk = 1'b0;
    logic          rst, start, n0p_done, rt_done, out_ready;
    logic [DL-1:0] n, r_in, t_in;
    logic [DW-1:0] n0p_in;

    logic [DL-1:0] n_lat_a, n_lat_b;
    logic [DW-1:0] r_a, t_a, n0p_a, r_b, t_b, n0p_b;
    logic [1:0]    widx_a, widx_b;
    logic          eng_start_a, out_valid_a, last_a, busy_a, done_a, error_a;
    logic          eng_start_b, out_valid_b, last_b, busy_b, done_b, error_b;
    logic [4:0]    st_a, st_b;

    assign st_a = {eng_start_a, out_valid_a, busy_a, done_a, error_a};
    assign st_b = {eng_start_b, out_valid_b, busy_b, done_b, error_b};

    always #5 clk = ~clk;

    rsa_precomp_streamer #(.DATA_LENGTH(DL), .DATA_WIDTH(DW), .MSW_FIRST(1), .TIMEOUT(16)) u_msw (
        .clk(clk), .rst(rst), .start(start), .n(n), .n_lat(n_lat_a), .eng_start(eng_start_a),
        .n0p_done(n0p_done), .rt_done(rt_done), .n0p_in(n0p_in), .r_in(r_in), .t_in(t_in),
        .out_valid(out_valid_a), .out_ready(out_ready), .r(r_a), .t(t_a), .n0p(n0p_a),
        .word_idx(widx_a), .last(last_a), .busy(busy_a), .done(done_a), .error(error_a));

    rsa_precomp_streamer #(.DATA_LENGTH(DL), .DATA_WIDTH(DW), .MSW_FIRST(0), .TIMEOUT(16)) u_lsw (
        .clk(clk), .rst(rst), .start(start), .n(n), .n_lat(n_lat_b), .eng_start(eng_start_b),
        .n0p_done(n0p_done), .rt_done(rt_done), .n0p_in(n0p_in), .r_in(r_in), .t_in(t_in),
        .out_valid(out_valid_b), .out_ready(out_ready), .r(r_b), .t(t_b), .n0p(n0p_b),
        .word_idx(widx_b), .last(last_b), .busy(busy_b), .done(done_b), .error(error_b));

    // One run: inputs plus expected stream start (cycles after LAUNCH, 0 = never).
    typedef struct {
        logic [DL-1:0] n;
        logic [DL-1:0] r;
        logic [DL-1:0] t;
        logic [DW-1:0] n0p;
        int            d_rt;      // rt_done cycle after LAUNCH
        int            d_n0;      // n0p_done cycle after LAUNCH, 0 = never
        int            rmode;     // 0 always ready, 1 fixed pattern, 2 random
        bit            dup;       // repeat each done one cycle later with junk data
        bit            xstart;    // pulse start while busy
        int            abort_at;  // reset once this many words transferred, 0 = none
        int            exp_ss;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cur     = 0;

    task automatic chk(input string name, input logic [DL-1:0] act, input logic [DL-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL run%0d %s: got %0h expected %0h", cur, name, act, exp);
        end
    endtask

    function automatic logic [DL-1:0] rnd256();
        logic [DL-1:0] v;
        v = '0;
        for (int j = 0; j < DL / 32; j++) v = {v[DL-33:0], $urandom()};
        return v;
    endfunction

    // Reference: split the value into words and pick word k in stream order.
    function automatic logic [DW-1:0] exp_word(input logic [DL-1:0] v, input int k, input bit msw);
        logic [DW-1:0] words [WORDS];
        for (int j = 0; j < WORDS; j++) words[j] = DW'(v >> (DW * j));
        return msw ? words[WORDS - 1 - k] : words[k];
    endfunction

    task automatic do_run(input vec_t v);
        int  ss, k, fin_c, p;
        bit  finished, rdy, do_rst, aborted, streaming;
        bit  rpat [7];
        rpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        ss = (v.exp_ss == 0) ? 1000000 : v.exp_ss;
        k = 0; fin_c = -1; finished = 0; aborted = 0;

        @(negedge clk);
        chk("idle_msw", 256'(st_a), 256'(5'b00000));
        chk("idle_lsw", 256'(st_b), 256'(5'b00000));
        start = 1'b1;
        n     = v.n;
        @(negedge clk);
        start = 1'b0;
        n     = rnd256();
        chk("launch_msw", 256'(st_a), 256'(5'b10100));
        chk("launch_lsw", 256'(st_b), 256'(5'b10100));
        chk("n_lat_launch", n_lat_a, v.n);

        for (int c = 1; c <= 300 && !finished; c++) begin
            @(negedge clk);
            rdy = 1'b0; do_rst = 1'b0; streaming = 1'b0;
            if (aborted) begin
                chk("abort_st_msw", 256'(st_a), 256'(5'b00000));
                chk("abort_st_lsw", 256'(st_b), 256'(5'b00000));
                chk("abort_r", 256'(r_a), 256'(0));
                chk("abort_idx", 256'(widx_b), 256'(0));
                finished = 1;
            end else if (v.exp_ss == 0) begin
`ifdef RSA_PRECOMP_TIMEOUT_EN
                chk("tmo_st_msw", 256'(st_a), 256'((c < 17) ? 5'b00100 : (c == 17) ? 5'b00001 : 5'b00000));
                chk("tmo_st_lsw", 256'(st_b), 256'((c < 17) ? 5'b00100 : (c == 17) ? 5'b00001 : 5'b00000));
                finished = (c == 18);
`else
                chk("nowait_st_msw", 256'(st_a), 256'((c <= 40) ? 5'b00100 : 5'b00000));
                chk("nowait_st_lsw", 256'(st_b), 256'((c <= 40) ? 5'b00100 : 5'b00000));
                do_rst   = (c == 40);
                finished = (c == 41);
`endif
            end else if (fin_c >= 0) begin
                chk("fin_st_msw", 256'(st_a), 256'((c == fin_c) ? 5'b00110 : 5'b00000));
                chk("fin_st_lsw", 256'(st_b), 256'((c == fin_c) ? 5'b00110 : 5'b00000));
                finished = (c == fin_c + 1);
            end else if (c < ss) begin
                chk("wait_st_msw", 256'(st_a), 256'(5'b00100));
                chk("wait_st_lsw", 256'(st_b), 256'(5'b00100));
            end else begin
                streaming = 1'b1;
                chk("strm_st_msw", 256'(st_a), 256'(5'b01100));
                chk("strm_st_lsw", 256'(st_b), 256'(5'b01100));
                chk("r_msw", 256'(r_a), 256'(exp_word(v.r, k, 1)));
                chk("t_msw", 256'(t_a), 256'(exp_word(v.t, k, 1)));
                chk("r_lsw", 256'(r_b), 256'(exp_word(v.r, k, 0)));
                chk("t_lsw", 256'(t_b), 256'(exp_word(v.t, k, 0)));
                chk("idx_msw", 256'(widx_a), 256'(k));
                chk("idx_lsw", 256'(widx_b), 256'(k));
                chk("last_msw", 256'(last_a), 256'(k == WORDS - 1));
                chk("last_lsw", 256'(last_b), 256'(k == WORDS - 1));
                if (c == ss) begin
                    chk("n0p_msw", 256'(n0p_a), 256'(v.n0p));
                    chk("n0p_lsw", 256'(n0p_b), 256'(v.n0p));
                    chk("n_lat_hold", n_lat_b, v.n);
                end
                p = c - ss;
                case (v.rmode)
                    0:       rdy = 1'b1;
                    1:       rdy = (p < 7) ? rpat[p] : 1'b1;
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                if (v.abort_at != 0 && k == v.abort_at) begin
                    do_rst  = 1'b1;
                    aborted = 1;
                end else if (rdy) begin
                    k++;
                    if (k == WORDS) fin_c = c + 1;
                end
            end

            // Drive this cycle's inputs.
            rst       = do_rst;
            rt_done   = (c == v.d_rt) || (v.dup && c == v.d_rt + 1);
            r_in      = (c == v.d_rt) ? v.r : rnd256();
            t_in      = (c == v.d_rt) ? v.t : rnd256();
            n0p_done  = (v.d_n0 != 0) && ((c == v.d_n0) || (v.dup && c == v.d_n0 + 1));
            n0p_in    = (c == v.d_n0) ? v.n0p : DW'(rnd256());
            start     = v.xstart && (c == 2);
            n         = rnd256();
            out_ready = streaming ? rdy : 1'($urandom_range(0, 1));
        end

        if (!finished) begin
            n_tests++;
            n_fail++;
            $display("FAIL run%0d run_bound: got no completion expected completion within 300 cycles", cur);
        end
        rst = 1'b0; start = 1'b0; rt_done = 1'b0; n0p_done = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        vec_t          tbl [7];
        vec_t          rv;
        logic [DL-1:0] ones, r34, t34;

        ones = '1;
        r34  = {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444};
        t34  = {64'haaaaaaaaaaaaaaaa, 64'hbbbbbbbbbbbbbbbb, 64'hcccccccccccccccc, 64'hdddddddddddddddd};
        //           n     r     t         n0p                 d_rt d_n0 rmode dup xstart abort ss
        tbl[0] = '{ones, r34, t34, 64'h0123456789abcdef, 5, 9, 0, 0, 0, 0, 10};
        tbl[1] = '{ones, r34, t34, 64'h0123456789abcdef, 5, 9, 1, 0, 0, 0, 10};
        tbl[2] = '{rnd256(), r34, t34, 64'hfedcba9876543210, 3, 2, 0, 0, 0, 2, 4};
        tbl[3] = '{rnd256(), rnd256(), rnd256(), 64'h5a5a5a5a5a5a5a5a, 3, 3, 0, 1, 1, 0, 4};
        tbl[4] = '{rnd256(), rnd256(), rnd256(), 64'h0f0f0f0f0f0f0f0f, 7, 2, 2, 1, 0, 0, 8};
        tbl[5] = '{rnd256(), rnd256(), rnd256(), 64'h0000000000000001, 1, 1, 0, 0, 0, 0, 2};
        tbl[6] = '{rnd256(), rnd256(), rnd256(), 64'h1234123412341234, 4, 0, 0, 0, 0, 0, 0};

        rst = 1'b1; start = 1'b0; n = '0; n0p_done = 1'b0; rt_done = 1'b0;
        n0p_in = '0; r_in = '0; t_in = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_st_msw", 256'(st_a), 256'(5'b00000));
        chk("rst_st_lsw", 256'(st_b), 256'(5'b00000));
        chk("rst_n_lat", n_lat_a, 256'(0));
        chk("rst_n0p", 256'(n0p_b), 256'(0));
        chk("rst_r_t", 256'({r_a, t_b}), 256'(0));
        chk("rst_idx_last", 256'({widx_a, last_a, widx_b, last_b}), 256'(0));

        // Reset wins over a simultaneous start.
        start = 1'b1; n = ones;
        @(negedge clk);
        chk("rst_prio_st", 256'(st_a), 256'(5'b00000));
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_prio_nolaunch", 256'(st_a), 256'(5'b00000));
        chk("rst_prio_n_lat", n_lat_b, 256'(0));

        for (int i = 0; i < 7; i++) begin
            cur = i;
            do_run(tbl[i]);
        end

        for (int i = 0; i < 12; i++) begin
            cur         = 100 + i;
            rv.n        = rnd256();
            rv.r        = rnd256();
            rv.t        = rnd256();
            rv.n0p      = DW'(rnd256());
            rv.d_rt     = int'($urandom_range(1, 12));
            rv.d_n0     = int'($urandom_range(1, 12));
            rv.rmode    = 2;
            rv.dup      = 1'($urandom_range(0, 1));
            rv.xstart   = 1'($urandom_range(0, 1));
            rv.abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            rv.exp_ss   = ((rv.d_rt > rv.d_n0) ? rv.d_rt : rv.d_n0) + 1;
            do_run(rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
